// File: rtl/pwm_duty_uart_rx.sv
// UART 8N1 receiver that holds the last good byte as the PWM duty word.
// Ports: clk, rst_i (sync, active-high), ena, rx_i -> duty_o, duty_valid_o,
//        frame_err_o (one-cycle pulses), busy_o (frame in progress).
module pwm_duty_uart_rx #(
    parameter int width        = 8,
    parameter int CLKS_PER_BIT = 1042
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             ena,
    input  logic             rx_i,
    output logic [width-1:0] duty_o,
    output logic             duty_valid_o,
    output logic             frame_err_o,
    output logic             busy_o
);

    localparam int IW = (width > 1) ? $clog2(width) : 1;
    localparam logic [15:0]   HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0]   BIT_M1  = 16'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST    = IW'(width - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t           state_q;
    logic [15:0]      cnt_q;
    logic [IW-1:0]    idx_q;
    logic [width-1:0] shift_q;
    logic [width-1:0] duty_q;
    logic             valid_q;
    logic             err_q;
    logic             rx_meta_q;
    logic             rx_s_q;

    // Two-flop synchronizer; runs regardless of ena
    always_ff @(posedge clk) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            duty_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (!ena) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s_q) begin
                        state_q <= START;
                    end
                end
                START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        idx_q <= '0;
                        // A start bit gone high by mid-bit is a glitch
                        state_q <= rx_s_q ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                DATA: begin
                    if (cnt_q == BIT_M1) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s_q, shift_q[width-1:1]};
                        if (idx_q == LAST) begin
                            state_q <= STOP;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                STOP: begin
                    if (cnt_q == BIT_M1) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            duty_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                BREAK: begin
                    // Hold off until the line returns high
                    cnt_q <= '0;
                    if (rx_s_q) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign duty_o       = duty_q;
    assign duty_valid_o = valid_q;
    assign frame_err_o  = err_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_pwm_duty_uart_rx.sv
// Directed bench for pwm_duty_uart_rx with CLKS_PER_BIT=16, width=8.
// Drives rx_i on falling edges, samples outputs on falling edges.
module tb_pwm_duty_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       ena;
    logic       rx_i;
    logic [7:0] duty_o;
    logic       duty_valid_o;
    logic       frame_err_o;
    logic       busy_o;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_valid = 0;
    int n_err   = 0;
    int t_valid = 0;

    logic [7:0] pwm_cnt = 8'd0;
    logic       pwm;

    pwm_duty_uart_rx #(.width(8), .CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst_i        (rst_i),
        .ena          (ena),
        .rx_i         (rx_i),
        .duty_o       (duty_o),
        .duty_valid_o (duty_valid_o),
        .frame_err_o  (frame_err_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        pwm_cnt <= pwm_cnt + 8'd1;
    end

    // Downstream PWM stage model: high while counter below duty
    assign pwm = (pwm_cnt < duty_o);

    // Count every high cycle, so a stretched pulse shows up as >1
    always @(negedge clk) begin
        if (duty_valid_o) begin
            n_valid = n_valid + 1;
            t_valid = cyc;
        end
        if (frame_err_o) n_err = n_err + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        rx_i = 1'b0;
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            hold(CPB);
        end
        rx_i = stop;
        hold(CPB);
    endtask

    // Start bit, nb full data bits, then half of the next bit
    task automatic send_part(input logic [7:0] b, input int nb);
        rx_i = 1'b0;
        hold(CPB);
        for (int i = 0; i < nb; i++) begin
            rx_i = b[i];
            hold(CPB);
        end
        rx_i = b[nb];
        hold(CPB / 2);
    endtask

    initial begin
        int v0, e0, t0, lat, hi;
        rst_i = 1'b1;
        ena   = 1'b1;
        rx_i  = 1'b1;
        hold(2);
        rst_i = 1'b0;
        hold(1);
        check("rst_duty", duty_o, 8'h00);
        check("rst_valid", duty_valid_o, 1'b0);
        check("rst_err", frame_err_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);

        // Single byte and latency
        v0 = n_valid;
        t0 = cyc;
        send(8'h80, 1'b1);
        hold(4);
        check("b80_pulses", n_valid - v0, 1);
        check("b80_duty", duty_o, 8'h80);
        check("b80_busy", busy_o, 1'b0);
        lat = t_valid - t0;
        check("b80_latency", (lat >= 154 && lat <= 156), 1'b1);

        // Back-to-back
        v0 = n_valid;
        send(8'hFF, 1'b1);
        send(8'h00, 1'b1);
        hold(4);
        check("b2b_pulses", n_valid - v0, 2);
        check("b2b_duty", duty_o, 8'h00);

        send(8'h80, 1'b1);
        hold(4);
        check("reload_duty", duty_o, 8'h80);

        // Framing error; line kept low afterwards
        v0 = n_valid;
        e0 = n_err;
        send(8'h5A, 1'b0);
        hold(20);
        check("ferr_pulses", n_err - e0, 1);
        check("ferr_novalid", n_valid - v0, 0);
        check("ferr_duty", duty_o, 8'h80);
        check("ferr_busy_low_line", busy_o, 1'b1);
        rx_i = 1'b1;
        hold(4);
        check("ferr_busy_release", busy_o, 1'b0);

        // Glitch
        v0 = n_valid;
        e0 = n_err;
        rx_i = 1'b0;
        hold(4);
        check("glitch_busy_high", busy_o, 1'b1);
        rx_i = 1'b1;
        hold(11);
        check("glitch_busy", busy_o, 1'b0);
        check("glitch_pulses", (n_valid - v0) + (n_err - e0), 0);
        check("glitch_duty", duty_o, 8'h80);

        // Reset mid-frame
        v0 = n_valid;
        e0 = n_err;
        send_part(8'h33, 4);
        rst_i = 1'b1;
        hold(2);
        rx_i  = 1'b1;
        rst_i = 1'b0;
        hold(2);
        check("mrst_duty", duty_o, 8'h00);
        check("mrst_busy", busy_o, 1'b0);
        check("mrst_pulses", (n_valid - v0) + (n_err - e0), 0);
        v0 = n_valid;
        send(8'h40, 1'b1);
        hold(4);
        check("mrst_next_pulses", n_valid - v0, 1);
        check("mrst_next_duty", duty_o, 8'h40);

        // ena drop mid-frame
        v0 = n_valid;
        e0 = n_err;
        send_part(8'h33, 4);
        ena = 1'b0;
        hold(2);
        check("ena_busy", busy_o, 1'b0);
        rx_i = 1'b1;
        hold(20);
        check("ena_duty", duty_o, 8'h40);
        check("ena_pulses", (n_valid - v0) + (n_err - e0), 0);
        ena = 1'b1;
        hold(2);
        v0 = n_valid;
        send(8'h40, 1'b1);
        hold(4);
        check("ena_next_pulses", n_valid - v0, 1);
        check("ena_next_duty", duty_o, 8'h40);

        // End-to-end PWM high time over one full period
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (pwm) hi++;
        end
        check("pwm_high", hi, 64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
